// File: rtl/cpu_regfile.sv
// cpu_regfile: SM83 register file (A, F, B, C, D, E, H, L, SP, PC, WZ).
//
// Ports
//   clk, reset            core clock, asynchronous active-high reset
//   rd_a_sel / rd_a       byte read port A (ALU operand A), combinational
//   rd_b_sel / rd_b       byte read port B (ALU operand B), combinational
//   wr_en/wr_sel/wr_data  byte write port
//   flag_wr_en/flag_in    flag load, {Z,N,H,C} with bit0 = C
//   flag_out              current flags, same order as flag_in
//   pair_sel/pair_op      16-bit pair port: none/inc/dec/load
//   pair_load/pair_out    pair load data / current (pre-update) pair value
//   pc_out                current PC
//
// Byte index: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 F, 7 A, 8 SPH, 9 SPL,
//             10 PCH, 11 PCL, 12 W, 13 Z, 14-15 unused (read 00).
// Pair index: 0 BC, 1 DE, 2 HL, 3 SP, 4 PC, 5 WZ, 6 AF, 7 none.
//
// Build option: define CPU_REGFILE_BOOT_STATE_EN to reset into the DMG
// post-boot-ROM register state instead of all zeros.
module cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rd_a_sel,
    output logic [7:0]  rd_a,
    input  logic [3:0]  rd_b_sel,
    output logic [7:0]  rd_b,
    input  logic        wr_en,
    input  logic [3:0]  wr_sel,
    input  logic [7:0]  wr_data,
    input  logic        flag_wr_en,
    input  logic [3:0]  flag_in,
    output logic [3:0]  flag_out,
    input  logic [2:0]  pair_sel,
    input  logic [1:0]  pair_op,
    input  logic [15:0] pair_load,
    output logic [15:0] pair_out,
    output logic [15:0] pc_out
);

    localparam int unsigned NUM_BYTES = 14;
    localparam logic [3:0]  IDX_LIMIT = 4'(NUM_BYTES);

    localparam logic [3:0] IDX_B   = 4'd0;
    localparam logic [3:0] IDX_C   = 4'd1;
    localparam logic [3:0] IDX_D   = 4'd2;
    localparam logic [3:0] IDX_E   = 4'd3;
    localparam logic [3:0] IDX_H   = 4'd4;
    localparam logic [3:0] IDX_L   = 4'd5;
    localparam logic [3:0] IDX_F   = 4'd6;
    localparam logic [3:0] IDX_A   = 4'd7;
    localparam logic [3:0] IDX_SPH = 4'd8;
    localparam logic [3:0] IDX_SPL = 4'd9;
    localparam logic [3:0] IDX_PCH = 4'd10;
    localparam logic [3:0] IDX_PCL = 4'd11;
    localparam logic [3:0] IDX_W   = 4'd12;
    localparam logic [3:0] IDX_Z   = 4'd13;

    localparam logic [2:0] PAIR_BC = 3'd0;
    localparam logic [2:0] PAIR_DE = 3'd1;
    localparam logic [2:0] PAIR_HL = 3'd2;
    localparam logic [2:0] PAIR_SP = 3'd3;
    localparam logic [2:0] PAIR_PC = 3'd4;
    localparam logic [2:0] PAIR_WZ = 3'd5;
    localparam logic [2:0] PAIR_AF = 3'd6;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_INC  = 2'd1;
    localparam logic [1:0] OP_DEC  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    // Reset image, index 13 (Z) leftmost down to index 0 (B).
`ifdef CPU_REGFILE_BOOT_STATE_EN
    localparam logic [NUM_BYTES-1:0][7:0] RESET_REGS = {
        8'h00, 8'h00,          // Z, W
        8'h00, 8'h01,          // PCL, PCH
        8'hFE, 8'hFF,          // SPL, SPH
        8'h01, 8'hB0,          // A, F
        8'h4D, 8'h01,          // L, H
        8'hD8, 8'h00,          // E, D
        8'h13, 8'h00           // C, B
    };
`else
    localparam logic [NUM_BYTES-1:0][7:0] RESET_REGS = '0;
`endif

    logic [NUM_BYTES-1:0][7:0] regs_q;
    logic [NUM_BYTES-1:0][7:0] regs_d;

    logic        pair_valid;
    logic [3:0]  pair_hi;
    logic [3:0]  pair_lo;
    logic [15:0] pair_cur;
    logic [15:0] pair_nxt;
    logic        pair_wr;

    function automatic logic [7:0] read_byte(input logic [NUM_BYTES-1:0][7:0] r,
                                             input logic [3:0] sel);
        return (sel < IDX_LIMIT) ? r[sel] : 8'h00;
    endfunction

    // Read ports: straight from registered state, no bypass.
    assign rd_a     = read_byte(regs_q, rd_a_sel);
    assign rd_b     = read_byte(regs_q, rd_b_sel);
    assign flag_out = regs_q[IDX_F][7:4];
    assign pc_out   = {regs_q[IDX_PCH], regs_q[IDX_PCL]};
    assign pair_out = pair_cur;

    // Pair select decode to high/low byte indices.
    always_comb begin
        pair_valid = 1'b1;
        pair_hi    = IDX_B;
        pair_lo    = IDX_C;
        case (pair_sel)
            PAIR_BC: begin pair_hi = IDX_B;   pair_lo = IDX_C;   end
            PAIR_DE: begin pair_hi = IDX_D;   pair_lo = IDX_E;   end
            PAIR_HL: begin pair_hi = IDX_H;   pair_lo = IDX_L;   end
            PAIR_SP: begin pair_hi = IDX_SPH; pair_lo = IDX_SPL; end
            PAIR_PC: begin pair_hi = IDX_PCH; pair_lo = IDX_PCL; end
            PAIR_WZ: begin pair_hi = IDX_W;   pair_lo = IDX_Z;   end
            PAIR_AF: begin pair_hi = IDX_A;   pair_lo = IDX_F;   end
            default: pair_valid = 1'b0;
        endcase
    end

    assign pair_cur = pair_valid ? {regs_q[pair_hi], regs_q[pair_lo]} : 16'h0000;

    // Pair arithmetic wraps modulo 2^16; AF only accepts loads.
    always_comb begin
        pair_nxt = pair_cur;
        case (pair_op)
            OP_INC:  pair_nxt = pair_cur + 16'd1;
            OP_DEC:  pair_nxt = pair_cur - 16'd1;
            OP_LOAD: pair_nxt = pair_load;
            default: pair_nxt = pair_cur;
        endcase
    end

    assign pair_wr = pair_valid && (pair_op != OP_NONE) &&
                     !((pair_sel == PAIR_AF) && (pair_op != OP_LOAD));

    // Next state: later assignments win, giving pair > flags > byte write.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_sel < IDX_LIMIT)) begin
            regs_d[wr_sel] = wr_data;
        end
        if (flag_wr_en) begin
            regs_d[IDX_F][7:4] = flag_in;
        end
        if (pair_wr) begin
            regs_d[pair_hi] = pair_nxt[15:8];
            regs_d[pair_lo] = pair_nxt[7:0];
        end
        regs_d[IDX_F][3:0] = 4'h0;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= RESET_REGS;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_cpu_regfile.sv
// Self-checking bench for cpu_regfile: reset state, a directed vector
// table, a mid-cycle reset sequence and randomized cycles against a
// register-level reference model.
module tb_cpu_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_a_sel, rd_b_sel, wr_sel, flag_in;
    logic [7:0]  rd_a, rd_b, wr_data;
    logic        wr_en, flag_wr_en;
    logic [3:0]  flag_out;
    logic [2:0]  pair_sel;
    logic [1:0]  pair_op;
    logic [15:0] pair_load, pair_out, pc_out;

    int unsigned checks = 0;
    int unsigned errors = 0;

    cpu_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .rd_a_sel   (rd_a_sel),
        .rd_a       (rd_a),
        .rd_b_sel   (rd_b_sel),
        .rd_b       (rd_b),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .flag_wr_en (flag_wr_en),
        .flag_in    (flag_in),
        .flag_out   (flag_out),
        .pair_sel   (pair_sel),
        .pair_op    (pair_op),
        .pair_load  (pair_load),
        .pair_out   (pair_out),
        .pc_out     (pc_out)
    );

    always #5 clk = ~clk;

    // Reference model: named 8-bit A/F and 16-bit pairs.
    logic [7:0]  m_a, m_f;
    logic [15:0] m_bc, m_de, m_hl, m_sp, m_pc, m_wz;

    task automatic m_reset();
`ifdef CPU_REGFILE_BOOT_STATE_EN
        m_a = 8'h01; m_f = 8'hB0;
        m_bc = 16'h0013; m_de = 16'h00D8; m_hl = 16'h014D;
        m_sp = 16'hFFFE; m_pc = 16'h0100; m_wz = 16'h0000;
`else
        m_a = 8'h00; m_f = 8'h00;
        m_bc = 16'h0; m_de = 16'h0; m_hl = 16'h0;
        m_sp = 16'h0; m_pc = 16'h0; m_wz = 16'h0;
`endif
    endtask

    function automatic logic [7:0] m_byte(input logic [3:0] s);
        case (s)
            4'd0:  return m_bc[15:8];
            4'd1:  return m_bc[7:0];
            4'd2:  return m_de[15:8];
            4'd3:  return m_de[7:0];
            4'd4:  return m_hl[15:8];
            4'd5:  return m_hl[7:0];
            4'd6:  return m_f;
            4'd7:  return m_a;
            4'd8:  return m_sp[15:8];
            4'd9:  return m_sp[7:0];
            4'd10: return m_pc[15:8];
            4'd11: return m_pc[7:0];
            4'd12: return m_wz[15:8];
            4'd13: return m_wz[7:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] m_pair(input logic [2:0] p);
        case (p)
            3'd0: return m_bc;
            3'd1: return m_de;
            3'd2: return m_hl;
            3'd3: return m_sp;
            3'd4: return m_pc;
            3'd5: return m_wz;
            3'd6: return {m_a, m_f};
            default: return 16'h0000;
        endcase
    endfunction

    // One clock edge: byte write, then flags, then pair op (later wins).
    task automatic m_step(input logic we, input logic [3:0] ws, input logic [7:0] wd,
                          input logic fwe, input logic [3:0] fi,
                          input logic [2:0] ps, input logic [1:0] po, input logic [15:0] pl);
        logic [15:0] pv, nv;
        pv = m_pair(ps);
        if (we) begin
            case (ws)
                4'd0:  m_bc[15:8] = wd;
                4'd1:  m_bc[7:0]  = wd;
                4'd2:  m_de[15:8] = wd;
                4'd3:  m_de[7:0]  = wd;
                4'd4:  m_hl[15:8] = wd;
                4'd5:  m_hl[7:0]  = wd;
                4'd6:  m_f = {wd[7:4], 4'h0};
                4'd7:  m_a = wd;
                4'd8:  m_sp[15:8] = wd;
                4'd9:  m_sp[7:0]  = wd;
                4'd10: m_pc[15:8] = wd;
                4'd11: m_pc[7:0]  = wd;
                4'd12: m_wz[15:8] = wd;
                4'd13: m_wz[7:0]  = wd;
                default: ;
            endcase
        end
        if (fwe) m_f = {fi, 4'h0};
        if (po != 2'd0 && ps != 3'd7 && !(ps == 3'd6 && po != 2'd3)) begin
            if (po == 2'd1)      nv = pv + 16'd1;
            else if (po == 2'd2) nv = pv - 16'd1;
            else                 nv = pl;
            case (ps)
                3'd0: m_bc = nv;
                3'd1: m_de = nv;
                3'd2: m_hl = nv;
                3'd3: m_sp = nv;
                3'd4: m_pc = nv;
                3'd5: m_wz = nv;
                default: begin m_a = nv[15:8]; m_f = {nv[7:4], 4'h0}; end
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_sel = 4'd0; wr_data = 8'h00;
        flag_wr_en = 1'b0; flag_in = 4'h0;
        pair_sel = 3'd7; pair_op = 2'd0; pair_load = 16'h0;
    endtask

    typedef struct {
        logic        we;  logic [3:0] ws; logic [7:0] wd;
        logic        fwe; logic [3:0] fi;
        logic [2:0]  ps;  logic [1:0] po; logic [15:0] pl;
        logic [3:0]  ra;  logic [3:0] rb; logic [2:0] rp;
        logic [7:0]  ea;  logic [7:0] eb; logic [15:0] ep;
        logic [3:0]  ef;  logic [15:0] epc;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [3:0] ws, input logic [7:0] wd,
                                input logic fwe, input logic [3:0] fi,
                                input logic [2:0] ps, input logic [1:0] po, input logic [15:0] pl,
                                input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] rp,
                                input logic [7:0] ea, input logic [7:0] eb, input logic [15:0] ep,
                                input logic [3:0] ef, input logic [15:0] epc);
        vec_t v;
        v.we = we; v.ws = ws; v.wd = wd; v.fwe = fwe; v.fi = fi;
        v.ps = ps; v.po = po; v.pl = pl; v.ra = ra; v.rb = rb; v.rp = rp;
        v.ea = ea; v.eb = eb; v.ep = ep; v.ef = ef; v.epc = epc;
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        // Directed sequence from all-zero reset state; each row is applied
        // for one edge, then the listed ports are read back.
        //            we ws     wd     fwe fi    ps    po    pl         ra     rb     rp    ea     eb     ep          ef    epc
        vecs[0]  = mk(1, 4'd6,  8'hFF, 0, 4'h0, 3'd0, 2'd0, 16'h0000, 4'd6,  4'd7,  3'd6, 8'hF0, 8'h00, 16'h00F0, 4'hF, 16'h0000);
        vecs[1]  = mk(0, 4'd0,  8'h00, 1, 4'h5, 3'd0, 2'd0, 16'h0000, 4'd6,  4'd7,  3'd6, 8'h50, 8'h00, 16'h0050, 4'h5, 16'h0000);
        vecs[2]  = mk(0, 4'd0,  8'h00, 0, 4'h0, 3'd3, 2'd3, 16'hFFFF, 4'd8,  4'd9,  3'd3, 8'hFF, 8'hFF, 16'hFFFF, 4'h5, 16'h0000);
        vecs[3]  = mk(0, 4'd0,  8'h00, 0, 4'h0, 3'd3, 2'd1, 16'h0000, 4'd8,  4'd9,  3'd3, 8'h00, 8'h00, 16'h0000, 4'h5, 16'h0000);
        vecs[4]  = mk(0, 4'd0,  8'h00, 0, 4'h0, 3'd3, 2'd2, 16'h0000, 4'd8,  4'd9,  3'd3, 8'hFF, 8'hFF, 16'hFFFF, 4'h5, 16'h0000);
        vecs[5]  = mk(0, 4'd0,  8'h00, 0, 4'h0, 3'd2, 2'd3, 16'h12FF, 4'd4,  4'd5,  3'd2, 8'h12, 8'hFF, 16'h12FF, 4'h5, 16'h0000);
        vecs[6]  = mk(1, 4'd5,  8'hAA, 0, 4'h0, 3'd2, 2'd1, 16'h0000, 4'd4,  4'd5,  3'd2, 8'h13, 8'h00, 16'h1300, 4'h5, 16'h0000);
        vecs[7]  = mk(0, 4'd0,  8'h00, 0, 4'h0, 3'd6, 2'd3, 16'hABCD, 4'd7,  4'd6,  3'd6, 8'hAB, 8'hC0, 16'hABC0, 4'hC, 16'h0000);
        vecs[8]  = mk(0, 4'd0,  8'h00, 0, 4'h0, 3'd6, 2'd1, 16'h0000, 4'd7,  4'd6,  3'd6, 8'hAB, 8'hC0, 16'hABC0, 4'hC, 16'h0000);
        vecs[9]  = mk(1, 4'd7,  8'h5A, 1, 4'h3, 3'd0, 2'd0, 16'h0000, 4'd7,  4'd6,  3'd6, 8'h5A, 8'h30, 16'h5A30, 4'h3, 16'h0000);
        vecs[10] = mk(1, 4'd14, 8'h77, 0, 4'h0, 3'd7, 2'd3, 16'h1234, 4'd14, 4'd15, 3'd7, 8'h00, 8'h00, 16'h0000, 4'h3, 16'h0000);
        vecs[11] = mk(1, 4'd6,  8'h00, 1, 4'hF, 3'd0, 2'd0, 16'h0000, 4'd6,  4'd7,  3'd6, 8'hF0, 8'h5A, 16'h5AF0, 4'hF, 16'h0000);
        vecs[12] = mk(0, 4'd0,  8'h00, 1, 4'h0, 3'd6, 2'd3, 16'h1290, 4'd7,  4'd6,  3'd6, 8'h12, 8'h90, 16'h1290, 4'h9, 16'h0000);
        vecs[13] = mk(0, 4'd0,  8'h00, 0, 4'h0, 3'd4, 2'd3, 16'h0100, 4'd10, 4'd11, 3'd4, 8'h01, 8'h00, 16'h0100, 4'h9, 16'h0100);
        vecs[14] = mk(0, 4'd0,  8'h00, 0, 4'h0, 3'd0, 2'd2, 16'h0000, 4'd0,  4'd1,  3'd0, 8'hFF, 8'hFF, 16'hFFFF, 4'h9, 16'h0100);
        vecs[15] = mk(1, 4'd12, 8'h3C, 0, 4'h0, 3'd0, 2'd0, 16'h0000, 4'd12, 4'd13, 3'd5, 8'h3C, 8'h00, 16'h3C00, 4'h9, 16'h0100);

        idle_inputs();
        rd_a_sel = 4'd0; rd_b_sel = 4'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_reset();

        // Reset state on every byte index and every pair.
        for (int s = 0; s < 16; s++) begin
            rd_a_sel = 4'(s); rd_b_sel = 4'(15 - s);
            #1;
            chk($sformatf("reset rd_a[%0d]", s), 16'(rd_a), 16'(m_byte(4'(s))));
            chk($sformatf("reset rd_b[%0d]", 15 - s), 16'(rd_b), 16'(m_byte(4'(15 - s))));
        end
        for (int p = 0; p < 8; p++) begin
            pair_sel = 3'(p);
            #1 chk($sformatf("reset pair[%0d]", p), pair_out, m_pair(3'(p)));
        end
        chk("reset pc_out", pc_out, m_pc);
        chk("reset flag_out", 16'(flag_out), 16'(m_f[7:4]));

`ifndef CPU_REGFILE_BOOT_STATE_EN
        // Directed table (assumes the all-zero reset image).
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            wr_en = vecs[i].we; wr_sel = vecs[i].ws; wr_data = vecs[i].wd;
            flag_wr_en = vecs[i].fwe; flag_in = vecs[i].fi;
            pair_sel = vecs[i].ps; pair_op = vecs[i].po; pair_load = vecs[i].pl;
            @(posedge clk);
            #1;
            idle_inputs();
            rd_a_sel = vecs[i].ra; rd_b_sel = vecs[i].rb; pair_sel = vecs[i].rp;
            #1;
            chk($sformatf("vec%0d rd_a", i), 16'(rd_a), 16'(vecs[i].ea));
            chk($sformatf("vec%0d rd_b", i), 16'(rd_b), 16'(vecs[i].eb));
            chk($sformatf("vec%0d pair_out", i), pair_out, vecs[i].ep);
            chk($sformatf("vec%0d flag_out", i), 16'(flag_out), 16'(vecs[i].ef));
            chk($sformatf("vec%0d pc_out", i), pc_out, vecs[i].epc);
        end
`endif

        // Reset asserted mid-cycle while writing B=55: write lost, state
        // drops before the next edge.
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_sel = 4'd0; wr_data = 8'h55;
        rd_a_sel = 4'd0; pair_sel = 3'd0;
        #2 reset = 1'b1;
        m_reset();
        #1;
        chk("midreset pc_out", pc_out, m_pc);
        chk("midreset flag_out", 16'(flag_out), 16'(m_f[7:4]));
        chk("midreset pair BC", pair_out, m_bc);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        reset = 1'b0;
        #1 chk("midreset B after edge", 16'(rd_a), 16'(m_byte(4'd0)));
        @(posedge clk);
        #1 chk("post reset B", 16'(rd_a), 16'(m_byte(4'd0)));

        // Randomized cycles against the model.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_sel     = 4'($urandom_range(0, 15));
            wr_data    = 8'($urandom);
            flag_wr_en = ($urandom_range(0, 3) == 0);
            flag_in    = 4'($urandom);
            pair_sel   = 3'($urandom_range(0, 7));
            pair_op    = 2'($urandom_range(0, 3));
            pair_load  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            rd_a_sel   = 4'($urandom_range(0, 15));
            rd_b_sel   = 4'($urandom_range(0, 15));
            #1;
            chk("rand rd_a", 16'(rd_a), 16'(m_byte(rd_a_sel)));
            chk("rand rd_b", 16'(rd_b), 16'(m_byte(rd_b_sel)));
            chk("rand pair_out", pair_out, m_pair(pair_sel));
            chk("rand flag_out", 16'(flag_out), 16'(m_f[7:4]));
            chk("rand pc_out", pc_out, m_pc);
            @(posedge clk);
            m_step(wr_en, wr_sel, wr_data, flag_wr_en, flag_in, pair_sel, pair_op, pair_load);
            #1 idle_inputs();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
